// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shifts, rotates, arithmetic shift, load and clear,
// with a registered carry-out and a zero flag derived from the next value of q.
module univ_shift_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic             so_msb,
  output logic             so_lsb
);

  localparam logic [WIDTH-1:0] L_RST = RESET_VAL[WIDTH-1:0];

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_zero;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_carry_nxt;
  logic             w_zero_nxt;

  always_comb begin
    w_q_nxt     = r_q;
    w_carry_nxt = r_carry;
    w_zero_nxt  = r_zero;
    if (en) begin
      case (mode)
        M_HOLD: begin
          w_q_nxt     = r_q;
          w_carry_nxt = r_carry;
        end
        M_SHL: begin
          w_q_nxt     = {r_q[WIDTH-2:0], sin_r};
          w_carry_nxt = r_q[WIDTH-1];
        end
        M_SHR: begin
          w_q_nxt     = {sin_l, r_q[WIDTH-1:1]};
          w_carry_nxt = r_q[0];
        end
        M_LOAD: begin
          w_q_nxt     = d;
          w_carry_nxt = 1'b0;
        end
        M_ROL: begin
          w_q_nxt     = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_carry_nxt = r_q[WIDTH-1];
        end
        M_ROR: begin
          w_q_nxt     = {r_q[0], r_q[WIDTH-1:1]};
          w_carry_nxt = r_q[0];
        end
        M_ASR: begin
          w_q_nxt     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_carry_nxt = r_q[0];
        end
        M_CLR: begin
          w_q_nxt     = '0;
          w_carry_nxt = 1'b0;
        end
        default: begin
          w_q_nxt     = r_q;
          w_carry_nxt = r_carry;
        end
      endcase
      // Zero tracks the value q is about to take, so it never lags q by a cycle.
      if (mode != M_HOLD) w_zero_nxt = (w_q_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= L_RST;
      r_carry <= 1'b0;
      r_zero  <= (L_RST == '0);
    end else begin
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
      r_zero  <= w_zero_nxt;
    end
  end

  assign q      = r_q;
  assign carry  = r_carry;
  assign zero   = r_zero;
  assign so_msb = r_q[WIDTH-1];
  assign so_lsb = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed steps on an 8-bit instance, then a random run
// on 8-, 2- and 32-bit instances against an arithmetic reference model.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = M_HOLD;
  logic [31:0] d = '0;
  logic        sin_r = 1'b0;
  logic        sin_l = 1'b0;

  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [31:0] q32;
  logic        c8, c2, c32, z8, z2, z32;
  logic        msb8, lsb8, msb2, lsb2, msb32, lsb32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(32'hA5)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d[7:0]),
    .sin_r(sin_r), .sin_l(sin_l), .q(q8), .carry(c8), .zero(z8),
    .so_msb(msb8), .so_lsb(lsb8));

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(32'h6)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d[1:0]),
    .sin_r(sin_r), .sin_l(sin_l), .q(q2), .carry(c2), .zero(z2),
    .so_msb(msb2), .so_lsb(lsb2));

  univ_shift_reg #(.WIDTH(32), .RESET_VAL(32'h0)) u_dut32 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q32), .carry(c32), .zero(z32),
    .so_msb(msb32), .so_lsb(lsb32));

  // Reference state per instance: 0 -> 8-bit, 1 -> 2-bit, 2 -> 32-bit.
  int              m_w  [3] = '{8, 2, 32};
  longint unsigned m_rv [3] = '{64'hA5, 64'h2, 64'h0};
  longint unsigned m_q  [3];
  bit              m_c  [3];
  bit              m_z  [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [31:0] dv,
                       input logic sr, input logic sl);
    en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
  endtask

  // Next state from the operation's arithmetic meaning, not bit slicing.
  function automatic void model_step(input int k, input bit rst, input bit e,
                                     input logic [2:0] m, input longint unsigned dv,
                                     input bit sr, input bit sl);
    longint unsigned full, half, qv;
    full = 64'd1 << m_w[k];
    half = 64'd1 << (m_w[k] - 1);
    qv   = m_q[k];
    if (rst) begin
      m_q[k] = m_rv[k] % full;
      m_c[k] = 1'b0;
      m_z[k] = (m_q[k] == 0);
      return;
    end
    if (!e || m == M_HOLD) return;
    case (m)
      M_SHL:  begin m_c[k] = (qv >= half); m_q[k] = (qv * 2 + sr) % full; end
      M_SHR:  begin m_c[k] = qv[0]; m_q[k] = qv / 2 + (sl ? half : 0); end
      M_LOAD: begin m_c[k] = 1'b0; m_q[k] = dv % full; end
      M_ROL:  begin m_c[k] = (qv >= half); m_q[k] = (qv * 2) % full + (qv >= half ? 1 : 0); end
      M_ROR:  begin m_c[k] = qv[0]; m_q[k] = qv / 2 + (qv[0] ? half : 0); end
      M_ASR:  begin m_c[k] = qv[0]; m_q[k] = qv / 2 + (qv >= half ? half : 0); end
      default: begin m_c[k] = 1'b0; m_q[k] = 0; end
    endcase
    m_z[k] = (m_q[k] == 0);
  endfunction

  logic [7:0] rol_exp [8] = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};

  initial begin
    // Reset, then idle cycles.
    reset = 1'b1; drive(1'b0, M_HOLD, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("rst_q", {24'h0, q8}, 32'hA5);
    chk("rst_carry", {31'h0, c8}, 32'h0);
    chk("rst_zero", {31'h0, z8}, 32'h0);
    chk("rst_so_msb", {31'h0, msb8}, 32'h1);
    chk("rst_so_lsb", {31'h0, lsb8}, 32'h1);
    chk("rst2_q", {30'h0, q2}, 32'h2);
    chk("rst32_zero", {31'h0, z32}, 32'h1);

    // Reset beats a LOAD on the same edge.
    reset = 1'b1; drive(1'b1, M_LOAD, 32'h0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    chk("rst_wins_q", {24'h0, q8}, 32'hA5);

    // Shift left then right through the boundary bits.
    drive(1'b1, M_LOAD, 32'h81, 1'b0, 1'b0); step();
    chk("load81_q", {24'h0, q8}, 32'h81);
    drive(1'b1, M_SHL, 32'hFF, 1'b0, 1'b0); step();
    chk("shl_q", {24'h0, q8}, 32'h02);
    chk("shl_carry", {31'h0, c8}, 32'h1);
    drive(1'b1, M_SHR, 32'hFF, 1'b1, 1'b1); step();
    chk("shr_q", {24'h0, q8}, 32'h81);
    chk("shr_carry", {31'h0, c8}, 32'h0);

    // Eight rotates return the original value.
    drive(1'b1, M_LOAD, 32'h96, 1'b0, 1'b0); step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, M_ROL, $urandom, 1'($urandom), 1'($urandom)); step();
      chk($sformatf("rol%0d_q", i), {24'h0, q8}, {24'h0, rol_exp[i]});
      chk($sformatf("rol%0d_zero", i), {31'h0, z8}, 32'h0);
    end
    chk("rol_final_carry", {31'h0, c8}, 32'h0);

    // ASR of a negative value saturates to all-ones.
    drive(1'b1, M_LOAD, 32'h80, 1'b0, 1'b0); step();
    repeat (7) begin drive(1'b1, M_ASR, 32'h0, 1'b0, 1'b0); step(); end
    chk("asr_neg_q", {24'h0, q8}, 32'hFF);
    chk("asr_neg_zero", {31'h0, z8}, 32'h0);

    // ASR of a positive value reaches zero; zero rises with q.
    drive(1'b1, M_LOAD, 32'h40, 1'b0, 1'b0); step();
    repeat (6) begin drive(1'b1, M_ASR, 32'h0, 1'b1, 1'b1); step(); end
    chk("asr_pos6_q", {24'h0, q8}, 32'h01);
    chk("asr_pos6_zero", {31'h0, z8}, 32'h0);
    drive(1'b1, M_ASR, 32'h0, 1'b1, 1'b1); step();
    chk("asr_pos7_q", {24'h0, q8}, 32'h00);
    chk("asr_pos7_zero", {31'h0, z8}, 32'h1);
    chk("asr_pos7_carry", {31'h0, c8}, 32'h1);

    // Disabled CLR holds everything; enabled CLR clears.
    drive(1'b1, M_LOAD, 32'h3C, 1'b0, 1'b0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, M_CLR, 32'h0, 1'b0, 1'b0); step();
      chk($sformatf("en0_q%0d", i), {24'h0, q8}, 32'h3C);
      chk($sformatf("en0_carry%0d", i), {31'h0, c8}, 32'h0);
      chk($sformatf("en0_zero%0d", i), {31'h0, z8}, 32'h0);
    end
    drive(1'b1, M_CLR, 32'hFF, 1'b1, 1'b1); step();
    chk("clr_q", {24'h0, q8}, 32'h0);
    chk("clr_zero", {31'h0, z8}, 32'h1);
    chk("clr_carry", {31'h0, c8}, 32'h0);

    // Random run: resync the models with a reset, then compare every cycle.
    reset = 1'b1; step();
    for (int k = 0; k < 3; k++) model_step(k, 1'b1, 1'b0, M_HOLD, 0, 1'b0, 1'b0);
    for (int n = 0; n < 10000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom,
            1'($urandom), 1'($urandom));
      step();
      for (int k = 0; k < 3; k++)
        model_step(k, reset, en, mode, longint'(d), sin_r, sin_l);
      chk("rnd8_q", {24'h0, q8}, 32'(m_q[0]));
      chk("rnd8_carry", {31'h0, c8}, {31'h0, m_c[0]});
      chk("rnd8_zero", {31'h0, z8}, {31'h0, m_z[0]});
      chk("rnd2_q", {30'h0, q2}, 32'(m_q[1]));
      chk("rnd2_carry", {31'h0, c2}, {31'h0, m_c[1]});
      chk("rnd2_zero", {31'h0, z2}, {31'h0, m_z[1]});
      chk("rnd32_q", q32, 32'(m_q[2]));
      chk("rnd32_carry", {31'h0, c32}, {31'h0, m_c[2]});
      chk("rnd32_zero", {31'h0, z32}, {31'h0, m_z[2]});
      chk("rnd32_so", {30'h0, msb32, lsb32},
          {30'h0, 1'(m_q[2] >> 31), 1'(m_q[2] & 1)});
      chk("rnd2_so", {30'h0, msb2, lsb2}, 32'(m_q[1]));
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
